// File: rtl/game_pkg.sv
// Shared map/physics constants and the player motion state type.
// Coordinates are signed with the origin at screen centre.
package game_pkg;

  typedef enum logic [1:0] {GROUND, AIR, DASH, HITSTUN} player_state_e;

  localparam int P_X_W       = 11;
  localparam int P_Y_W       = 10;
  localparam int MAP_X_MIN   = -304;
  localparam int MAP_X_MAX   = 304;
  localparam int MAP_X_START = -280;
  localparam int MAP_Y_GND   = -200;

  localparam int PHY_STEP_X    = 4;
  localparam int PHY_JUMP_V    = 20;
  localparam int PHY_GRAV      = 2;
  localparam int PHY_AIR_JUMPS = 1;
  localparam int PHY_DASH_STEP = 12;
  localparam int PHY_DASH_LEN  = 6;
  localparam int PHY_DASH_CD   = 30;
  localparam int PHY_KB_STEP   = 6;
  localparam int PHY_KB_LEN    = 8;

  // Bits needed to hold 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/player_vphys.sv
// Vertical integrator: y += vy, then gravity or jump reload, with ground landing.
module player_vphys
  import game_pkg::*;
#(
  parameter int Y_W    = P_Y_W,
  parameter int Y_GND  = MAP_Y_GND,
  parameter int JUMP_V = PHY_JUMP_V,
  parameter int GRAV   = PHY_GRAV
) (
  input  logic signed [Y_W-1:0] i_y,
  input  logic signed [Y_W-1:0] i_vy,
  input  logic                  i_jump_load,
  input  logic                  i_grounded_hold,
  output logic signed [Y_W-1:0] o_y_next,
  output logic signed [Y_W-1:0] o_vy_next,
  output logic                  o_landed
);

  localparam logic signed [Y_W+1:0] GND_E = (Y_W+2)'(Y_GND);
  localparam logic signed [Y_W-1:0] GND_S = Y_W'(Y_GND);
  localparam logic signed [Y_W-1:0] JV_S  = Y_W'(JUMP_V);
  localparam logic signed [Y_W-1:0] GR_S  = Y_W'(GRAV);

  logic signed [Y_W+1:0] w_sum;

  always_comb begin
    w_sum     = {{2{i_y[Y_W-1]}}, i_y} + {{2{i_vy[Y_W-1]}}, i_vy};
    o_y_next  = i_y;
    o_vy_next = i_vy;
    o_landed  = 1'b0;
    if (!i_grounded_hold) begin
      if (w_sum <= GND_E) begin
        o_y_next  = GND_S;
        o_vy_next = '0;
        o_landed  = 1'b1;
      end else begin
        o_y_next  = w_sum[Y_W-1:0];
        o_vy_next = i_jump_load ? JV_S : i_vy - GR_S;
      end
    end
  end

endmodule

// File: rtl/player_motion.sv
// Tick-stepped player movement controller: GROUND/AIR/DASH/HITSTUN with
// jump physics, air jumps, dash cooldown and knockback.
module player_motion
  import game_pkg::*;
#(
  parameter int X_W       = P_X_W,
  parameter int Y_W       = P_Y_W,
  parameter int X_MIN     = MAP_X_MIN,
  parameter int X_MAX     = MAP_X_MAX,
  parameter int X_START   = MAP_X_START,
  parameter int Y_GND     = MAP_Y_GND,
  parameter int STEP_X    = PHY_STEP_X,
  parameter int JUMP_V    = PHY_JUMP_V,
  parameter int GRAV      = PHY_GRAV,
  parameter int AIR_JUMPS = PHY_AIR_JUMPS,
  parameter int DASH_STEP = PHY_DASH_STEP,
  parameter int DASH_LEN  = PHY_DASH_LEN,
  parameter int DASH_CD   = PHY_DASH_CD,
  parameter int KB_STEP   = PHY_KB_STEP,
  parameter int KB_LEN    = PHY_KB_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  right,
  input  logic                  left,
  input  logic                  jump,
  input  logic                  squat,
  input  logic                  defend,
  input  logic                  dash,
  input  logic                  hit,
  input  logic                  hit_dir,
  output logic signed [X_W-1:0] x,
  output logic signed [Y_W-1:0] y,
  output logic                  isJ,
  output logic                  isQ,
  output logic                  isD,
  output logic                  isDash,
  output logic                  isHit,
  output logic                  facing,
  output logic                  dash_ready
);

  localparam int unsigned CD_W  = cnt_width(DASH_CD);
  localparam int unsigned CNT_W = cnt_width((DASH_LEN > KB_LEN) ? DASH_LEN : KB_LEN);
  localparam int unsigned AJ_W  = cnt_width(AIR_JUMPS);

  localparam logic [CD_W-1:0]        CD_LOAD  = CD_W'(DASH_CD);
  localparam logic [CNT_W-1:0]       DLEN     = CNT_W'(DASH_LEN);
  localparam logic [CNT_W-1:0]       KLEN     = CNT_W'(KB_LEN);
  localparam logic [AJ_W-1:0]        AJ_MAX   = AJ_W'(AIR_JUMPS);
  localparam logic signed [X_W+1:0]  XMIN_E   = (X_W+2)'(X_MIN);
  localparam logic signed [X_W+1:0]  XMAX_E   = (X_W+2)'(X_MAX);
  localparam logic signed [X_W+1:0]  STEP_E   = (X_W+2)'(STEP_X);
  localparam logic signed [X_W+1:0]  DSTEP_E  = (X_W+2)'(DASH_STEP);
  localparam logic signed [X_W+1:0]  KSTEP_E  = (X_W+2)'(KB_STEP);
  localparam logic signed [X_W-1:0]  XSTART_S = X_W'(X_START);
  localparam logic signed [Y_W-1:0]  GND_S    = Y_W'(Y_GND);
  localparam logic signed [Y_W-1:0]  JV_S     = Y_W'(JUMP_V);

  player_state_e         r_state, w_state_nx;
  logic signed [X_W-1:0] r_x, w_x_nx;
  logic signed [Y_W-1:0] r_y, w_y_nx;
  logic signed [Y_W-1:0] r_vy, w_vy_nx;
  logic                  r_facing, w_facing_nx;
  logic [CD_W-1:0]       r_cd, w_cd_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic [AJ_W-1:0]       r_aj, w_aj_nx;
  logic                  r_kbdir, w_kbdir_nx;
  logic                  r_jprev;

  logic                  w_jedge, w_jump_load, w_grounded_hold, w_landed;
  logic signed [Y_W-1:0] w_y_phys, w_vy_phys;
  logic signed [X_W+1:0] w_walk_dx, w_dx, w_xsum;

  assign w_jedge         = jump & ~r_jprev;
  assign w_jump_load     = (r_state == AIR) & w_jedge & (r_aj < AJ_MAX);
  assign w_grounded_hold = (r_state == HITSTUN) ? !(r_y > GND_S) : (r_state != AIR);
  assign w_walk_dx       = right ? STEP_E : (left ? -STEP_E : '0);

  player_vphys #(
    .Y_W   (Y_W),
    .Y_GND (Y_GND),
    .JUMP_V(JUMP_V),
    .GRAV  (GRAV)
  ) u_vphys (
    .i_y            (r_y),
    .i_vy           (r_vy),
    .i_jump_load    (w_jump_load),
    .i_grounded_hold(w_grounded_hold),
    .o_y_next       (w_y_phys),
    .o_vy_next      (w_vy_phys),
    .o_landed       (w_landed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= GROUND;
      r_x      <= XSTART_S;
      r_y      <= GND_S;
      r_vy     <= '0;
      r_facing <= 1'b1;
      r_cd     <= '0;
      r_cnt    <= '0;
      r_aj     <= '0;
      r_kbdir  <= 1'b0;
      r_jprev  <= 1'b0;
    end else if (tick) begin
      r_state  <= w_state_nx;
      r_x      <= w_x_nx;
      r_y      <= w_y_nx;
      r_vy     <= w_vy_nx;
      r_facing <= w_facing_nx;
      r_cd     <= w_cd_nx;
      r_cnt    <= w_cnt_nx;
      r_aj     <= w_aj_nx;
      r_kbdir  <= w_kbdir_nx;
      r_jprev  <= jump;
    end
  end

  // A tick that starts a hit or dash only switches state; motion begins next tick.
  always_comb begin
    w_state_nx  = r_state;
    w_y_nx      = r_y;
    w_vy_nx     = r_vy;
    w_facing_nx = r_facing;
    w_cnt_nx    = r_cnt;
    w_aj_nx     = r_aj;
    w_kbdir_nx  = r_kbdir;
    w_cd_nx     = (r_cd != '0) ? r_cd - 1'b1 : r_cd;
    w_dx        = '0;
    case (r_state)
      GROUND: begin
        if (hit) begin
          if (!defend) begin
            w_state_nx = HITSTUN;
            w_cnt_nx   = KLEN;
            w_kbdir_nx = hit_dir;
          end
        end else if (dash && r_cd == '0 && !defend) begin
          w_state_nx = DASH;
          w_cnt_nx   = DLEN;
          w_cd_nx    = CD_LOAD;
        end else if (w_jedge) begin
          w_state_nx = AIR;
          w_vy_nx    = JV_S;
          w_aj_nx    = '0;
        end else begin
          if (right)     w_facing_nx = 1'b1;
          else if (left) w_facing_nx = 1'b0;
          if (!defend && !squat) w_dx = w_walk_dx;
        end
      end
      AIR: begin
        if (hit) begin
          w_state_nx = HITSTUN;
          w_cnt_nx   = KLEN;
          w_kbdir_nx = hit_dir;
        end else if (dash && r_cd == '0 && !defend) begin
          w_state_nx = DASH;
          w_cnt_nx   = DLEN;
          w_cd_nx    = CD_LOAD;
          w_vy_nx    = '0;
        end else begin
          if (right)     w_facing_nx = 1'b1;
          else if (left) w_facing_nx = 1'b0;
          w_dx    = w_walk_dx;
          w_y_nx  = w_y_phys;
          w_vy_nx = w_vy_phys;
          if (w_landed)         w_state_nx = GROUND;
          else if (w_jump_load) w_aj_nx    = r_aj + 1'b1;
        end
      end
      DASH: begin
        if (hit) begin
          w_state_nx = HITSTUN;
          w_cnt_nx   = KLEN;
          w_kbdir_nx = hit_dir;
        end else begin
          w_dx     = r_facing ? DSTEP_E : -DSTEP_E;
          w_cnt_nx = r_cnt - 1'b1;
          if (w_cnt_nx == '0) begin
            w_vy_nx = '0;
            if (r_y == GND_S) w_state_nx = GROUND;
            else              w_state_nx = AIR;
          end
        end
      end
      HITSTUN: begin
        w_y_nx  = w_y_phys;
        w_vy_nx = w_vy_phys;
        if (hit) begin
          w_cnt_nx   = KLEN;
          w_kbdir_nx = hit_dir;
          w_dx       = hit_dir ? KSTEP_E : -KSTEP_E;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
          w_dx     = r_kbdir ? KSTEP_E : -KSTEP_E;
          if (w_cnt_nx == '0) begin
            if (w_y_phys == GND_S) w_state_nx = GROUND;
            else                   w_state_nx = AIR;
          end
        end
      end
      default: w_state_nx = GROUND;
    endcase

    w_xsum = {{2{r_x[X_W-1]}}, r_x} + w_dx;
    if (w_xsum < XMIN_E)      w_xsum = XMIN_E;
    else if (w_xsum > XMAX_E) w_xsum = XMAX_E;
    w_x_nx = w_xsum[X_W-1:0];
  end

  always_comb begin
    x          = r_x;
    y          = r_y;
    facing     = r_facing;
    isJ        = (r_state == AIR);
    isDash     = (r_state == DASH);
    isHit      = (r_state == HITSTUN);
    isD        = defend && (r_state == GROUND);
    isQ        = squat && !defend && (r_state == GROUND);
    dash_ready = (r_cd == '0) && (r_state == GROUND || r_state == AIR);
  end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with a cycle-compared behavioural model.
module tb_player_motion;

  logic clk = 1'b0;
  logic rst_n, tick, right, left, jump, squat, defend, dash, hit, hit_dir;
  logic signed [10:0] x;
  logic signed [9:0]  y;
  logic isJ, isQ, isD, isDash, isHit, facing, dash_ready;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  player_motion #(.AIR_JUMPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .right(right), .left(left),
    .jump(jump), .squat(squat), .defend(defend), .dash(dash), .hit(hit),
    .hit_dir(hit_dir), .x(x), .y(y), .isJ(isJ), .isQ(isQ), .isD(isD),
    .isDash(isDash), .isHit(isHit), .facing(facing), .dash_ready(dash_ready)
  );

  // Model: the active action is whichever timer is running, else airborne/ground.
  int m_x, m_y, m_vy, m_cd, m_dash, m_stun, m_aj;
  bit m_facing, m_jprev, m_air, m_kb;

  function automatic int clampx(input int v);
    return (v < -304) ? -304 : ((v > 304) ? 304 : v);
  endfunction

  task automatic model_reset();
    m_x = -280; m_y = -200; m_vy = 0; m_cd = 0; m_dash = 0; m_stun = 0;
    m_aj = 0; m_facing = 1'b1; m_jprev = 1'b0; m_air = 1'b0; m_kb = 1'b0;
  endtask

  task automatic steer(input bit move);
    if (right)     m_facing = 1'b1;
    else if (left) m_facing = 1'b0;
    if (move) begin
      if (right)     m_x = clampx(m_x + 4);
      else if (left) m_x = clampx(m_x - 4);
    end
  endtask

  task automatic fall(input bit reload);
    int ny;
    ny = m_y + m_vy;
    if (ny <= -200) begin
      m_y = -200; m_vy = 0; m_air = 1'b0;
    end else begin
      m_y = ny;
      if (reload) begin m_vy = 20; m_aj++; end
      else m_vy -= 2;
    end
  endtask

  task automatic start_stun();
    m_dash = 0; m_stun = 8; m_kb = hit_dir;
  endtask

  task automatic model_step();
    bit edge_;
    int cd_old;
    edge_ = jump && !m_jprev;
    m_jprev = jump;
    cd_old = m_cd;
    if (m_cd > 0) m_cd--;
    if (m_stun > 0) begin
      if (hit) begin m_kb = hit_dir; m_stun = 8; end
      else m_stun--;
      m_x = clampx(m_x + (m_kb ? 6 : -6));
      if (m_y > -200) fall(1'b0);
      if (m_stun == 0) m_air = (m_y != -200);
    end else if (m_dash > 0) begin
      if (hit) start_stun();
      else begin
        m_x = clampx(m_x + (m_facing ? 12 : -12));
        m_dash--;
        if (m_dash == 0) begin m_air = (m_y != -200); m_vy = 0; end
      end
    end else if (m_air) begin
      if (hit) start_stun();
      else if (dash && cd_old == 0 && !defend) begin m_dash = 6; m_cd = 30; m_vy = 0; end
      else begin steer(1'b1); fall(edge_ && m_aj < 1); end
    end else begin
      if (hit) begin if (!defend) start_stun(); end
      else if (dash && cd_old == 0 && !defend) begin m_dash = 6; m_cd = 30; end
      else if (edge_) begin m_air = 1'b1; m_vy = 20; m_aj = 0; end
      else steer(!defend && !squat);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    model_reset();
    else if (tick) model_step();
  end

  always @(negedge clk) begin
    bit e_hit, e_dash, e_air, e_gnd;
    logic [6:0] e_fl, a_fl;
    if (cmp_en) begin
      e_hit  = (m_stun > 0);
      e_dash = !e_hit && (m_dash > 0);
      e_air  = !e_hit && !e_dash && m_air;
      e_gnd  = !e_hit && !e_dash && !m_air;
      e_fl = {e_air, squat && !defend && e_gnd, defend && e_gnd, e_dash, e_hit,
              m_facing, (m_cd == 0) && (e_gnd || e_air)};
      a_fl = {isJ, isQ, isD, isDash, isHit, facing, dash_ready};
      n_checks++;
      if (int'(x) == m_x && int'(y) == m_y && a_fl === e_fl) n_pass++;
      else $display("FAIL model_cmp @%0t: got x=%0d y=%0d JQDdHfr=%b, want x=%0d y=%0d JQDdHfr=%b",
                    $time, x, y, a_fl, m_x, m_y, e_fl);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    right = 0; left = 0; jump = 0; squat = 0; defend = 0; dash = 0; hit = 0; hit_dir = 0;
  endtask

  task automatic do_reset();
    tick = 0;
    clear_inputs();
    @(negedge clk);
    #2 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    cmp_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, ymax;
    rst_n = 1; tick = 0;
    clear_inputs();

    // Reset state and left clamp
    do_reset();
    chk("rst_x", x, -280);
    chk("rst_y", y, -200);
    chk("rst_facing", facing, 1);
    chk("rst_ready", dash_ready, 1);
    chk("rst_flags", {isJ, isQ, isD, isDash, isHit}, 0);
    tick = 1; left = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) chk("walk_x5", x, -300);
      if (i == 6) chk("walk_x6", x, -304);
    end
    chk("walk_clamp", x, -304);
    chk("walk_facing", facing, 0);

    // Single jump arc, held jump must not retrigger
    do_reset();
    tick = 1; jump = 1;
    step();
    chk("jump_entry_isJ", isJ, 1);
    chk("jump_entry_y", y, -200);
    cnt = isJ;
    for (int i = 1; i <= 21; i++) begin
      if (i == 3) jump = 0;
      step();
      cnt += isJ;
      if (i == 1)  chk("jump_y1", y, -180);
      if (i == 10) chk("jump_apex10", y, -90);
      if (i == 11) chk("jump_apex11", y, -90);
    end
    chk("jump_land_y", y, -200);
    chk("jump_land_isJ", isJ, 0);
    chk("jump_isJ_ticks", cnt, 21);

    // Dash, retry during cooldown, cooldown expiry
    do_reset();
    tick = 1; dash = 1;
    step();
    dash = 0;
    chk("dash_ready_0", dash_ready, 0);
    cnt = isDash;
    for (int k = 1; k <= 30; k++) begin
      if (k == 20) dash = 1;
      if (k == 21) dash = 0;
      step();
      cnt += isDash;
      if (k == 6)  chk("dash_x", x, -208);
      if (k == 6)  chk("dash_ready_end", dash_ready, 0);
      if (k == 20) chk("dash_retry_ignored", isDash, 0);
      if (k == 29) chk("dash_cd29", dash_ready, 0);
    end
    chk("dash_cd30", dash_ready, 1);
    chk("dash_ticks", cnt, 6);
    chk("dash_x_final", x, -208);

    // Grounded knockback ignoring move/jump, then a blocked hit
    do_reset();
    tick = 1; right = 1;
    repeat (70) step();
    chk("walk_to_0", x, 0);
    hit = 1; hit_dir = 1; jump = 1;
    step();
    hit = 0;
    chk("hit_entry_x", x, 0);
    cnt = isHit;
    for (int k = 1; k <= 8; k++) begin
      jump = ~jump;
      step();
      cnt += isHit;
    end
    chk("hit_x", x, 48);
    chk("hit_ticks", cnt, 8);
    chk("hit_no_jump", isJ, 0);
    right = 0; jump = 0; defend = 1; hit = 1;
    step();
    chk("block_isHit", isHit, 0);
    chk("block_x", x, 48);
    chk("block_isD", isD, 1);
    hit = 0; defend = 0;
    step();

    // Air jump at apex; a third edge is ignored
    do_reset();
    tick = 1; jump = 1;
    step();
    jump = 0;
    repeat (10) step();
    chk("aj_apex", y, -90);
    jump = 1;
    step();
    chk("aj_reload_y", y, -90);
    jump = 0;
    step();
    chk("aj_first_rise", y, -70);
    step();
    step();
    jump = 1;
    step();
    chk("aj_third_ignored", y, -22);
    jump = 0;
    ymax = y;
    for (int k = 0; k < 40 && isJ; k++) begin
      step();
      if (y > ymax) ymax = y;
    end
    chk("aj_peak", ymax, 20);
    chk("aj_landed", isJ, 0);
    chk("aj_land_y", y, -200);

    // Asynchronous reset mid-dash, then tick=0 freeze
    do_reset();
    tick = 1; dash = 1;
    step();
    dash = 0;
    step();
    step();
    chk("predash_x", x, -256);
    #3 rst_n = 0;
    #2;
    chk("arst_x", x, -280);
    chk("arst_y", y, -200);
    chk("arst_flags", {isJ, isQ, isD, isDash, isHit}, 0);
    chk("arst_ready", dash_ready, 1);
    #1 rst_n = 1;
    right = 1;
    repeat (3) step();
    right = 0; dash = 1;
    step();
    dash = 0;
    step();
    chk("freeze_pre_x", x, -256);
    tick = 0;
    for (int k = 0; k < 10; k++) begin
      hit = k[0]; jump = ~k[0]; left = k[1]; dash = 1;
      step();
    end
    chk("freeze_x", x, -256);
    chk("freeze_y", y, -200);
    chk("freeze_isDash", isDash, 1);
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
